reg_file_8x16: RTL and testbench

- Architectural general-purpose register file for the RISC datapath, built directly on the rising-edge D flip-flop storage stage.
- Consumes the flip-flop outputs as storage bits.
- Feeds operands to the ALU/decode stage through two asynchronous read ports.
- Takes write-back data through one synchronous write port.
- Register 0 is hard-wired to zero.

---
 rtl/reg_file_8x16_pkg.sv | 22 ++
 rtl/reg_file_8x16_word.sv | 33 +++
 rtl/reg_file_8x16.sv | 61 ++++++
 tb/tb_reg_file_8x16.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_8x16_pkg.sv
// Shared constants for the 8x16 architectural register file.
// WIDTH/DEPTH/AW size the array. ZERO_REG is the hard-wired zero index.
// reg_idx_e names R0..R7 for the decode logic and the bench.
package reg_file_8x16_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned AW       = 3;
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic [AW-1:0] {
    R0 = 3'd0,
    R1 = 3'd1,
    R2 = 3'd2,
    R3 = 3'd3,
    R4 = 3'd4,
    R5 = 3'd5,
    R6 = 3'd6,
    R7 = 3'd7
  } reg_idx_e;

endpackage

// File: rtl/reg_file_8x16_word.sv
// One W-bit register word made of rising-edge D flip-flops with asynchronous clear.
// Each bit has a hold/load mux on its D input, selected by the word enable.
// Ports:
//   clk - clock input
//   rst - asynchronous clear input, active-high
//   en  - load enable input
//   d   - load data input
//   q   - stored word output
module reg_word #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  for (genvar b = 0; b < W; b++) begin : g_bit
    logic bit_q;
    logic bit_d;

    assign bit_d = en ? d[b] : bit_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) bit_q <= 1'b0;
      else     bit_q <= bit_d;
    end

    assign q[b] = bit_q;
  end

endmodule

// File: rtl/reg_file_8x16.sv
// General-purpose register file: DEPTH x WIDTH, with register 0 hard-wired to zero.
// It has two combinational read ports and one synchronous write port.
// A read of a register being written in the same cycle returns the old value (no bypass).
// Ports:
//   CLK - clock input
//   R   - asynchronous active-high reset input; clears every register
//   WE  - write enable input
//   WA  - write address input
//   WD  - write data input
//   RA1 - read address input, port 1
//   RA2 - read address input, port 2
//   RD1 - read data output, port 1
//   RD2 - read data output, port 2
module reg_file_8x16 #(
  parameter int unsigned WIDTH = reg_file_8x16_pkg::WIDTH,
  parameter int unsigned DEPTH = reg_file_8x16_pkg::DEPTH,
  parameter int unsigned AW    = reg_file_8x16_pkg::AW
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [AW-1:0]    RA1,
  input  logic [AW-1:0]    RA2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2
);

  import reg_file_8x16_pkg::*;

  // The decoder covers only the indices that have storage. Index 0 never gets an enable,
  // so writes to it are dropped.
  logic [DEPTH-1:1] we_dec;
  logic [WIDTH-1:0] regs [DEPTH];

  always_comb begin
    we_dec = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      we_dec[i] = WE && (WA == AW'(i));
    end
  end

  assign regs[ZERO_REG] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_word
    reg_word #(
      .W (WIDTH)
    ) u_word (
      .clk (CLK),
      .rst (R),
      .en  (we_dec[i]),
      .d   (WD),
      .q   (regs[i])
    );
  end

  assign RD1 = (RA1 == AW'(ZERO_REG)) ? '0 : regs[RA1];
  assign RD2 = (RA2 == AW'(ZERO_REG)) ? '0 : regs[RA2];

endmodule

// File: tb/tb_reg_file_8x16.sv
`timescale 1ns/1ps
module tb_reg_file_8x16;
  import reg_file_8x16_pkg::*;

  logic        CLK;
  logic        R;
  logic        WE;
  logic [2:0]  WA;
  logic [15:0] WD;
  logic [2:0]  RA1;
  logic [2:0]  RA2;
  logic [15:0] RD1;
  logic [15:0] RD2;

  reg_file_8x16 #(
    .WIDTH (16),
    .DEPTH (8),
    .AW    (3)
  ) dut (
    .CLK (CLK),
    .R   (R),
    .WE  (WE),
    .WA  (WA),
    .WD  (WD),
    .RA1 (RA1),
    .RA2 (RA2),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [15:0] exp1;
    logic [15:0] exp2;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [8];
  int          checks;
  int          errors;

  // Drive read addresses, push the model's expectation, then pop and compare after settling.
  task automatic rd(input string tag, input logic [2:0] a1, input logic [2:0] a2);
    exp_t e;
    exp_t g;
    RA1 = a1;
    RA2 = a2;
    e.tag  = tag;
    e.exp1 = (a1 == 3'd0) ? 16'h0000 : model[a1];
    e.exp2 = (a2 == 3'd0) ? 16'h0000 : model[a2];
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    checks++;
    assert (RD1 === g.exp1) else begin
      errors++;
      $error("FAIL %s RD1 ra=%0d got=%h exp=%h", g.tag, a1, RD1, g.exp1);
    end
    checks++;
    assert (RD2 === g.exp2) else begin
      errors++;
      $error("FAIL %s RD2 ra=%0d got=%h exp=%h", g.tag, a2, RD2, g.exp2);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge CLK);
    WE = 1'b1;
    WA = a;
    WD = d;
    @(posedge CLK);
    #1;
    if (a != 3'd0) model[a] = d;
    WE = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_model();
    R = 1'b1; WE = 1'b0; WA = '0; WD = '0; RA1 = '0; RA2 = '0;

    // Reset state
    @(negedge CLK);
    for (int i = 0; i < 8; i++) rd("reset_init", 3'(i), 3'(7 - i));
    @(negedge CLK);
    R = 1'b0;

    // Write then read every register, with port 2 walking in reverse order
    for (int i = 1; i < 8; i++) wr(3'(i), 16'(16'h1111 * i));
    @(negedge CLK);
    for (int i = 1; i < 8; i++) rd("wr_all", 3'(i), 3'(8 - i));

    // Both read ports on the same register
    rd("same_addr", R6, R6);

    // A write to register 0 is discarded
    wr(R0, 16'hFFFF);
    for (int i = 0; i < 8; i++) rd("reg0", R0, 3'(i));

    // Read during write: old value before the edge, new value after it
    wr(R3, 16'hAAAA);
    @(negedge CLK);
    WE = 1'b1; WA = R3; WD = 16'h5555;
    rd("rdw_before", R3, R3);
    @(posedge CLK);
    #1;
    model[3] = 16'h5555;
    WE = 1'b0;
    rd("rdw_after", R3, R3);

    // WE low holds every register across three edges
    @(negedge CLK);
    WE = 1'b0; WA = R5; WD = 16'hBEEF;
    repeat (3) @(posedge CLK);
    #1;
    rd("we_gate", R5, R5);
    for (int i = 1; i < 8; i++) rd("we_gate_all", 3'(i), 3'(i));

    // Mid-run reset clears the array before any clock edge
    @(negedge CLK);
    R = 1'b1;
    clear_model();
    for (int i = 0; i < 8; i++) rd("reset_mid", 3'(i), 3'(7 - i));
    repeat (2) @(negedge CLK);
    R = 1'b0;
    for (int i = 0; i < 8; i++) rd("reset_rel", 3'(i), 3'(i));

    // The first edge after release can write
    wr(R2, 16'h7777);
    rd("post_rel_wr", R2, R1);

    // Reset rising with a write edge: reset wins
    @(negedge CLK);
    WE = 1'b1; WA = R2; WD = 16'h1234;
    @(posedge CLK);
    R = 1'b1;
    clear_model();
    @(negedge CLK);
    WE = 1'b0;
    R = 1'b0;
    #1;
    rd("collision", R2, R2);
    rd("collision_bit", 3'(ZERO_REG), R2);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain got=%0d exp=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
